// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// instruction type codes, FSM states and scoreboard entry layout.
package pipe_hazard_ctrl_pkg;

    localparam logic [3:0] R_TYPE           = 4'd0;
    localparam logic [3:0] I_TYPE           = 4'd1;
    localparam logic [3:0] L_TYPE           = 4'd2;
    localparam logic [3:0] S_TYPE           = 4'd3;
    localparam logic [3:0] B_TYPE           = 4'd4;
    localparam logic [3:0] JAL_TYPE         = 4'd5;
    localparam logic [3:0] JALR_TYPE        = 4'd6;
    localparam logic [3:0] U_TYPE           = 4'd7;
    localparam logic [3:0] CSR_TYPE         = 4'd8;
    localparam logic [3:0] E_TYPE_MRET_TYPE = 4'd9;
    localparam logic [3:0] FENCE_TYPE       = 4'd10;

    typedef enum logic [1:0] {
        PHC_RUN    = 2'd0,
        PHC_DRAIN  = 2'd1,
        PHC_SERIAL = 2'd2
    } phc_state_e;

    // Entry = {valid, rd_wen, rd[AW-1:0], is_load, is_serial}
    localparam int PHC_SB_FLAGS = 4;
    localparam int PHC_AW       = 5;
    localparam int PHC_SB_W     = PHC_AW + PHC_SB_FLAGS;

    function automatic int phc_sb_width(input int aw);
        return aw + PHC_SB_FLAGS;
    endfunction

    function automatic logic is_serial_type(input logic [3:0] t);
        return (t == CSR_TYPE) || (t == E_TYPE_MRET_TYPE) ||
               (t == FENCE_TYPE);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sb_stage.sv
// One in-flight scoreboard entry (EX, MEM or WB slot).
// Clear wins over load; otherwise the entry holds.
module phc_sb_stage
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int W = PHC_SB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Entry register: clear to invalid, load new entry, or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use hazards,
// memory back-pressure and serialisation of CSR/ECALL/MRET/FENCE.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int AW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [3:0]    id_inst_type,
    input  logic          id_rs1_ren,
    input  logic          id_rs2_ren,
    input  logic [AW-1:0] id_rs1_addr,
    input  logic [AW-1:0] id_rs2_addr,
    input  logic          id_rd_wen,
    input  logic [AW-1:0] id_rd_addr,
    input  logic          id_branch_taken,
    input  logic          mem_busy,
    output logic          pc_stall,
    output logic          if_id_stall,
    output logic          if_id_flush,
    output logic          id_ex_bubble,
    output logic          ex_mem_stall,
    output logic          id_fire,
    output logic          wb_serial_retire
);

    localparam int W     = phc_sb_width(AW);
    localparam int V_B   = W - 1;
    localparam int WEN_B = W - 2;
    localparam int LD_B  = 1;

    phc_state_e   state;
    logic [3:0]   ser_type;
    logic [W-1:0] ser_q;

    logic [W-1:0] ex_q;
    logic [W-1:0] mem_q;
    logic [W-1:0] wb_q;
    logic [W-1:0] ex_d;

    logic id_is_load;
    logic id_is_serial;
    logic rs1_chk;
    logic rs2_chk;
    logic ex_match;
    logic mem_match;
    logic hazard;
    logic sb_empty;
    logic fire;
    logic retire;
    logic redirect;

    assign id_is_load   = (id_inst_type == L_TYPE);
    assign id_is_serial = is_serial_type(id_inst_type);

    assign ex_d = {1'b1, id_rd_wen, id_rd_addr, id_is_load, id_is_serial};

    phc_sb_stage #(.W(W)) u_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!mem_busy && !fire),
        .load  (!mem_busy && fire),
        .d     (ex_d),
        .q     (ex_q)
    );

    phc_sb_stage #(.W(W)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .load  (!mem_busy),
        .d     (ex_q),
        .q     (mem_q)
    );

    // A stalled MEM access still lets the WB slot drain
    phc_sb_stage #(.W(W)) u_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mem_busy),
        .load  (!mem_busy),
        .d     (mem_q),
        .q     (wb_q)
    );

    assign rs1_chk = id_rs1_ren && (id_rs1_addr != '0);
    assign rs2_chk = id_rs2_ren && (id_rs2_addr != '0);

    assign ex_match = ex_q[V_B] && ex_q[WEN_B] &&
        ((rs1_chk && (id_rs1_addr == ex_q[AW+1:2])) ||
         (rs2_chk && (id_rs2_addr == ex_q[AW+1:2])));

    assign mem_match = mem_q[V_B] && mem_q[WEN_B] &&
        ((rs1_chk && (id_rs1_addr == mem_q[AW+1:2])) ||
         (rs2_chk && (id_rs2_addr == mem_q[AW+1:2])));

    // With forwarding only an unfinished load blocks issue
    assign hazard = FWD_EN
        ? ((ex_match && ex_q[LD_B]) ||
           (mem_match && mem_q[LD_B] && mem_busy))
        : (ex_match || mem_match);

    assign sb_empty = !ex_q[V_B] && !mem_q[V_B] && !wb_q[V_B];

    assign fire = id_valid && !mem_busy &&
        (((state == PHC_RUN) && !hazard && !id_is_serial) ||
         ((state == PHC_DRAIN) && sb_empty));

    // The issued serial entry is recognised when it reaches WB
    assign retire = (state == PHC_SERIAL) && (wb_q == ser_q);

    assign redirect = (id_inst_type == JAL_TYPE) ||
                      (id_inst_type == JALR_TYPE) ||
                      ((id_inst_type == B_TYPE) && id_branch_taken);

    // Serialisation sequencer: drain, issue alone, wait for retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PHC_RUN;
            ser_type <= '0;
            ser_q    <= '0;
        end else begin
            unique case (state)
                PHC_RUN: begin
                    if (id_valid && id_is_serial) begin
                        state <= PHC_DRAIN;
                    end
                end
                PHC_DRAIN: begin
                    if (fire) begin
                        state    <= PHC_SERIAL;
                        ser_type <= id_inst_type;
                        ser_q    <= ex_d;
                    end
                end
                PHC_SERIAL: begin
                    if (retire) begin
                        state <= PHC_RUN;
                    end
                end
                default: state <= PHC_RUN;
            endcase
        end
    end

    // Outputs are forced low while reset is asserted
    always_comb begin
        id_fire          = rst_n && fire;
        pc_stall         = rst_n && id_valid && !fire;
        if_id_stall      = rst_n && id_valid && !fire;
        id_ex_bubble     = rst_n && !fire && !mem_busy;
        ex_mem_stall     = rst_n && mem_busy;
        wb_serial_retire = rst_n && retire;
        if_id_flush      = rst_n &&
            ((fire && redirect) ||
             (retire && (ser_type == E_TYPE_MRET_TYPE)));
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one instance with forwarding and one
// without, driven from a table of per-cycle vectors.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    typedef struct {
        bit         first;
        bit         fwd;
        logic       v;
        logic [3:0] t;
        logic       r1en;
        logic [4:0] rs1;
        logic       r2en;
        logic [4:0] rs2;
        logic       wen;
        logic [4:0] rd;
        logic       bt;
        logic       busy;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        bit         fwd;
        logic [6:0] val;
        string      nm;
    } exp_t;

    // {fire, stall, flush, bubble, ex_mem_stall, retire}
    localparam logic [5:0] E_F    = 6'b100000;
    localparam logic [5:0] E_SB   = 6'b010100;
    localparam logic [5:0] E_BUB  = 6'b000100;
    localparam logic [5:0] E_FF   = 6'b101000;
    localparam logic [5:0] E_BS   = 6'b010010;
    localparam logic [5:0] E_BSI  = 6'b000010;
    localparam logic [5:0] E_RET  = 6'b010101;
    localparam logic [5:0] E_RETF = 6'b011101;
    localparam logic [5:0] E_RETI = 6'b000101;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_inst_type;
    logic       id_rs1_ren;
    logic       id_rs2_ren;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_rd_wen;
    logic [4:0] id_rd_addr;
    logic       id_branch_taken;
    logic       mem_busy;

    logic fire1, pcs1, ifs1, fl1, bub1, exs1, ret1;
    logic fire0, pcs0, ifs0, fl0, bub0, exs0, ret0;

    int passed = 0;
    int total  = 0;

    vec_t tbl[$];
    exp_t exp_q[$];

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .AW(5)) dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_inst_type     (id_inst_type),
        .id_rs1_ren       (id_rs1_ren),
        .id_rs2_ren       (id_rs2_ren),
        .id_rs1_addr      (id_rs1_addr),
        .id_rs2_addr      (id_rs2_addr),
        .id_rd_wen        (id_rd_wen),
        .id_rd_addr       (id_rd_addr),
        .id_branch_taken  (id_branch_taken),
        .mem_busy         (mem_busy),
        .pc_stall         (pcs1),
        .if_id_stall      (ifs1),
        .if_id_flush      (fl1),
        .id_ex_bubble     (bub1),
        .ex_mem_stall     (exs1),
        .id_fire          (fire1),
        .wb_serial_retire (ret1)
    );

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .AW(5)) dut0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_inst_type     (id_inst_type),
        .id_rs1_ren       (id_rs1_ren),
        .id_rs2_ren       (id_rs2_ren),
        .id_rs1_addr      (id_rs1_addr),
        .id_rs2_addr      (id_rs2_addr),
        .id_rd_wen        (id_rd_wen),
        .id_rd_addr       (id_rd_addr),
        .id_branch_taken  (id_branch_taken),
        .mem_busy         (mem_busy),
        .pc_stall         (pcs0),
        .if_id_stall      (ifs0),
        .if_id_flush      (fl0),
        .id_ex_bubble     (bub0),
        .ex_mem_stall     (exs0),
        .id_fire          (fire0),
        .wb_serial_retire (ret0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t ins(bit first, bit fwd, logic [3:0] t,
                                 int rs1, int rs2, int rd,
                                 bit bt, bit busy, logic [5:0] exp);
        vec_t x;
        x.first = first;
        x.fwd   = fwd;
        x.v     = 1'b1;
        x.t     = t;
        x.r1en  = 1'b1;
        x.rs1   = 5'(rs1);
        x.r2en  = 1'b1;
        x.rs2   = 5'(rs2);
        x.wen   = (rd != 0);
        x.rd    = 5'(rd);
        x.bt    = bt;
        x.busy  = busy;
        x.exp   = exp;
        return x;
    endfunction

    function automatic vec_t idle(bit fwd, bit busy, logic [5:0] exp);
        vec_t x;
        x = ins(1'b0, fwd, R_TYPE, 0, 0, 0, 1'b0, busy, exp);
        x.v = 1'b0;
        return x;
    endfunction

    function automatic logic [6:0] expand(logic [5:0] e);
        return {e[5], e[4], e[4], e[3:0]};
    endfunction

    task automatic drive(input vec_t x);
        id_valid        = x.v;
        id_inst_type    = x.t;
        id_rs1_ren      = x.r1en;
        id_rs1_addr     = x.rs1;
        id_rs2_ren      = x.r2en;
        id_rs2_addr     = x.rs2;
        id_rd_wen       = x.wen;
        id_rd_addr      = x.rd;
        id_branch_taken = x.bt;
        mem_busy        = x.busy;
    endtask

    task automatic check_one();
        exp_t e;
        logic [6:0] got;
        e = exp_q.pop_front();
        if (e.fwd) got = {fire1, pcs1, ifs1, fl1, bub1, exs1, ret1};
        else       got = {fire0, pcs0, ifs0, fl0, bub0, exs0, ret0};
        total++;
        if (got !== e.val) begin
            $display("FAIL %s fwd=%0d got=%b want=%b",
                     e.nm, e.fwd, got, e.val);
        end else begin
            passed++;
        end
    endtask

    // Called at posedge+1; leaves the bench at the next posedge+1
    task automatic do_reset(input bit chk);
        rst_n = 1'b0;
        drive(ins(1'b0, 1'b1, B_TYPE, 1, 2, 3, 1'b1, 1'b1, E_F));
        #1;
        if (chk) begin
            exp_q.push_back('{fwd: 1'b1, val: 7'd0, nm: "reset_fwd1"});
            exp_q.push_back('{fwd: 1'b0, val: 7'd0, nm: "reset_fwd0"});
            check_one();
            check_one();
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step(input vec_t x, input string nm);
        drive(x);
        exp_q.push_back('{fwd: x.fwd, val: expand(x.exp), nm: nm});
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t x;
        rst_n = 1'b0;
        drive(idle(1'b1, 1'b0, E_BUB));

        // back-to-back ALU dependency, unread rs ignored
        tbl.push_back(ins(1, 1, R_TYPE, 1, 2, 5, 0, 0, E_F));
        tbl.push_back(ins(0, 1, R_TYPE, 5, 1, 6, 0, 0, E_F));
        tbl.push_back(ins(0, 1, L_TYPE, 1, 0, 5, 0, 0, E_F));
        x = ins(0, 1, R_TYPE, 5, 0, 7, 0, 0, E_F);
        x.r1en = 1'b0;
        tbl.push_back(x);
        tbl.push_back(idle(1, 0, E_BUB));

        // load-use with forwarding, rs1 and rs2
        tbl.push_back(ins(1, 1, L_TYPE, 1, 0, 5, 0, 0, E_F));
        tbl.push_back(ins(0, 1, R_TYPE, 5, 1, 6, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, R_TYPE, 5, 1, 6, 0, 0, E_F));
        tbl.push_back(ins(0, 1, R_TYPE, 6, 5, 7, 0, 0, E_F));
        tbl.push_back(ins(0, 1, L_TYPE, 1, 0, 8, 0, 0, E_F));
        tbl.push_back(ins(0, 1, R_TYPE, 2, 8, 9, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, R_TYPE, 2, 8, 9, 0, 0, E_F));
        tbl.push_back(idle(1, 0, E_BUB));

        // no forwarding: two stall cycles for load and ALU producers
        tbl.push_back(ins(1, 0, L_TYPE, 1, 0, 5, 0, 0, E_F));
        tbl.push_back(ins(0, 0, R_TYPE, 5, 1, 6, 0, 0, E_SB));
        tbl.push_back(ins(0, 0, R_TYPE, 5, 1, 6, 0, 0, E_SB));
        tbl.push_back(ins(0, 0, R_TYPE, 5, 1, 6, 0, 0, E_F));
        tbl.push_back(ins(0, 0, R_TYPE, 1, 2, 10, 0, 0, E_F));
        tbl.push_back(ins(0, 0, R_TYPE, 10, 0, 11, 0, 0, E_SB));
        tbl.push_back(ins(0, 0, R_TYPE, 10, 0, 11, 0, 0, E_SB));
        tbl.push_back(ins(0, 0, R_TYPE, 10, 0, 11, 0, 0, E_F));

        // mem_busy for 3 cycles while the load sits in MEM
        tbl.push_back(ins(1, 1, L_TYPE, 1, 0, 5, 0, 0, E_F));
        tbl.push_back(ins(0, 1, R_TYPE, 1, 2, 7, 0, 0, E_F));
        tbl.push_back(ins(0, 1, R_TYPE, 5, 1, 6, 0, 1, E_BS));
        tbl.push_back(ins(0, 1, R_TYPE, 5, 1, 6, 0, 1, E_BS));
        tbl.push_back(ins(0, 1, R_TYPE, 5, 1, 6, 0, 1, E_BS));
        tbl.push_back(ins(0, 1, R_TYPE, 5, 1, 6, 0, 0, E_F));
        tbl.push_back(idle(1, 1, E_BSI));
        tbl.push_back(idle(1, 0, E_BUB));

        // branches and jumps: flush only when the redirect fires
        tbl.push_back(ins(1, 1, L_TYPE, 1, 0, 5, 0, 0, E_F));
        tbl.push_back(ins(0, 1, B_TYPE, 5, 0, 0, 1, 0, E_SB));
        tbl.push_back(ins(0, 1, B_TYPE, 5, 0, 0, 1, 0, E_FF));
        tbl.push_back(ins(0, 1, L_TYPE, 1, 0, 8, 0, 0, E_F));
        tbl.push_back(ins(0, 1, B_TYPE, 8, 0, 0, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, B_TYPE, 8, 0, 0, 0, 0, E_F));
        tbl.push_back(ins(0, 1, JAL_TYPE, 0, 0, 1, 0, 0, E_FF));
        tbl.push_back(ins(0, 1, B_TYPE, 2, 3, 0, 1, 1, E_BS));
        tbl.push_back(ins(0, 1, B_TYPE, 2, 3, 0, 1, 0, E_FF));
        tbl.push_back(ins(0, 1, JALR_TYPE, 1, 0, 0, 0, 0, E_FF));
        tbl.push_back(idle(1, 0, E_BUB));

        // CSR after three ALU ops: drain, issue, serial, retire
        tbl.push_back(ins(1, 1, R_TYPE, 1, 2, 10, 0, 0, E_F));
        tbl.push_back(ins(0, 1, R_TYPE, 1, 2, 11, 0, 0, E_F));
        tbl.push_back(ins(0, 1, R_TYPE, 1, 2, 12, 0, 0, E_F));
        tbl.push_back(ins(0, 1, CSR_TYPE, 1, 0, 13, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, CSR_TYPE, 1, 0, 13, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, CSR_TYPE, 1, 0, 13, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, CSR_TYPE, 1, 0, 13, 0, 0, E_F));
        tbl.push_back(ins(0, 1, R_TYPE, 13, 0, 14, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, R_TYPE, 13, 0, 14, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, R_TYPE, 13, 0, 14, 0, 0, E_RET));
        tbl.push_back(ins(0, 1, R_TYPE, 13, 0, 14, 0, 0, E_F));
        tbl.push_back(idle(1, 0, E_BUB));

        // ECALL: flush accompanies the retire strobe
        tbl.push_back(ins(1, 1, E_TYPE_MRET_TYPE, 0, 0, 0, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, E_TYPE_MRET_TYPE, 0, 0, 0, 0, 0, E_F));
        tbl.push_back(ins(0, 1, R_TYPE, 1, 2, 3, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, R_TYPE, 1, 2, 3, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, R_TYPE, 1, 2, 3, 0, 0, E_RETF));
        tbl.push_back(ins(0, 1, R_TYPE, 1, 2, 3, 0, 0, E_F));

        // FENCE behind a load, retiring with ID empty
        tbl.push_back(ins(1, 1, L_TYPE, 1, 0, 5, 0, 0, E_F));
        tbl.push_back(ins(0, 1, FENCE_TYPE, 0, 0, 0, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, FENCE_TYPE, 0, 0, 0, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, FENCE_TYPE, 0, 0, 0, 0, 0, E_SB));
        tbl.push_back(ins(0, 1, FENCE_TYPE, 0, 0, 0, 0, 0, E_F));
        tbl.push_back(idle(1, 0, E_BUB));
        tbl.push_back(idle(1, 0, E_BUB));
        tbl.push_back(idle(1, 0, E_RETI));
        tbl.push_back(idle(1, 0, E_BUB));

        @(posedge clk);
        #1;
        do_reset(1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].first) do_reset(1'b0);
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // reset asserted mid-SERIAL on the non-forwarding instance
        do_reset(1'b0);
        step(ins(0, 0, CSR_TYPE, 1, 0, 5, 0, 0, E_SB), "ser_drain");
        step(ins(0, 0, CSR_TYPE, 1, 0, 5, 0, 0, E_F), "ser_fire");
        step(ins(0, 0, R_TYPE, 5, 0, 6, 0, 0, E_SB), "ser_wait");
        rst_n = 1'b0;
        #2;
        exp_q.push_back('{fwd: 1'b0, val: 7'd0, nm: "midrst_fwd0"});
        exp_q.push_back('{fwd: 1'b1, val: 7'd0, nm: "midrst_fwd1"});
        check_one();
        check_one();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_q.push_back('{fwd: 1'b0, val: expand(E_F), nm: "postrst_fire"});
        check_one();
        @(posedge clk);
        #1;
        step(ins(0, 0, R_TYPE, 6, 0, 7, 0, 0, E_SB), "postrst_dep");
        step(ins(0, 0, R_TYPE, 6, 0, 7, 0, 0, E_SB), "postrst_dep2");
        step(ins(0, 0, R_TYPE, 6, 0, 7, 0, 0, E_F), "postrst_go");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
